// File: rtl/uart_serial_link.sv
// uart_serial_link: full-duplex 8N1 UART with side-band parity wires.
//
// The transmitter and receiver are independent. Each bit lasts
// TICK_DIVISOR*OVERSAMPLE clocks. Parity never appears in the serial frame.
//
// Ports
//   i_clock        system clock, rising edge
//   i_reset        asynchronous reset, active low
//   i_rx_data      serial input, idle high
//   i_tx_signal    transmit request, acted on at its rising edge
//   i_tx_result    byte to send, captured at the request edge
//   i_parity       partner's parity for the byte being received (bit 0 used)
//   o_rx_done      one-cycle pulse when a valid byte lands in o_rx_data
//   o_rx_data      last valid received byte
//   o_parity       even parity of the byte being / last transmitted
//   o_tx_data      serial output, idle high
//   o_tx_done      one-cycle pulse at the end of the stop bit(s)
//   o_tx_available high while the transmitter is idle
module uart_serial_link #(
    parameter int DATA_WIDTH   = 8,
    parameter int STOP_WIDTH   = 1,
    parameter int PARITY_WIDTH = 1,
    parameter int TICK_DIVISOR = 16,
    parameter int OVERSAMPLE   = 16
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_rx_data,
    input  logic                    i_tx_signal,
    input  logic [DATA_WIDTH-1:0]   i_tx_result,
    input  logic [PARITY_WIDTH-1:0] i_parity,
    output logic                    o_rx_done,
    output logic [DATA_WIDTH-1:0]   o_rx_data,
    output logic [PARITY_WIDTH-1:0] o_parity,
    output logic                    o_tx_data,
    output logic                    o_tx_done,
    output logic                    o_tx_available
);

    localparam int BIT_CLKS = TICK_DIVISOR * OVERSAMPLE;
    localparam int CW = $clog2(BIT_CLKS);
    localparam int BW = $clog2(DATA_WIDTH + STOP_WIDTH + 1);
    localparam int DW = $clog2(TICK_DIVISOR);
    localparam int OW = $clog2(OVERSAMPLE);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIVISOR - 1);
    localparam logic [OW-1:0] MID_TICK  = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] BIT_TICK  = OW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- transmitter ----------------
    state_t                    tx_state, tx_state_n;
    logic [CW-1:0]             tx_cnt, tx_cnt_n;
    logic [BW-1:0]             tx_idx, tx_idx_n;
    logic [DATA_WIDTH-1:0]     tx_shift, tx_shift_n;
    logic                      tx_sig_q, tx_req, tx_line_n, tx_done_n;
    logic [PARITY_WIDTH-1:0]   parity_n;

    assign tx_req         = i_tx_signal & ~tx_sig_q;
    assign o_tx_available = (tx_state == IDLE);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tx_state  <= IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            tx_sig_q  <= 1'b0;
            o_tx_data <= 1'b1;
            o_tx_done <= 1'b0;
            o_parity  <= '0;
        end else begin
            tx_state  <= tx_state_n;
            tx_cnt    <= tx_cnt_n;
            tx_idx    <= tx_idx_n;
            tx_shift  <= tx_shift_n;
            tx_sig_q  <= i_tx_signal;
            o_tx_data <= tx_line_n;
            o_tx_done <= tx_done_n;
            o_parity  <= parity_n;
        end
    end

    // The bit counter restarts at the accepted request, so bit edges are
    // aligned to the request rather than to any free-running tick.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_line_n  = o_tx_data;
        tx_done_n  = 1'b0;
        parity_n   = o_parity;
        case (tx_state)
            IDLE: begin
                tx_line_n = 1'b1;
                if (tx_req) begin
                    tx_shift_n  = i_tx_result;
                    parity_n    = '0;
                    parity_n[0] = ^i_tx_result;
                    tx_cnt_n    = '0;
                    tx_idx_n    = '0;
                    tx_line_n   = 1'b0;
                    tx_state_n  = START;
                end
            end
            START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_line_n  = tx_shift[0];
                    tx_state_n = DATA;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_idx == DATA_LAST) begin
                        tx_idx_n   = '0;
                        tx_line_n  = 1'b1;
                        tx_state_n = STOP;
                    end else begin
                        tx_idx_n   = tx_idx + 1'b1;
                        tx_shift_n = tx_shift >> 1;
                        tx_line_n  = tx_shift_n[0];
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_idx == STOP_LAST) begin
                        tx_idx_n   = '0;
                        tx_done_n  = 1'b1;
                        tx_state_n = IDLE;
                    end else begin
                        tx_idx_n = tx_idx + 1'b1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    state_t                rx_state, rx_state_n;
    logic                  rx_meta, rx_sync, tick;
    logic [DW-1:0]         rx_div;
    logic [OW-1:0]         rx_tcnt, rx_tcnt_n;
    logic [BW-1:0]         rx_idx, rx_idx_n;
    logic [DATA_WIDTH-1:0] rx_shift, rx_shift_n, rx_data_n;
    logic                  rx_stop_ok, rx_stop_ok_n, stop_ok_now, rx_done_n;

    assign tick = (rx_div == DIV_LAST);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_div     <= '0;
            rx_state   <= IDLE;
            rx_tcnt    <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_stop_ok <= 1'b1;
            o_rx_done  <= 1'b0;
            o_rx_data  <= '0;
        end else begin
            rx_meta    <= i_rx_data;
            rx_sync    <= rx_meta;
            rx_div     <= tick ? '0 : rx_div + 1'b1;
            rx_state   <= rx_state_n;
            rx_tcnt    <= rx_tcnt_n;
            rx_idx     <= rx_idx_n;
            rx_shift   <= rx_shift_n;
            rx_stop_ok <= rx_stop_ok_n;
            o_rx_done  <= rx_done_n;
            o_rx_data  <= rx_data_n;
        end
    end

    // Start is re-checked half a bit in (glitch reject); every later sample
    // is a whole bit further, landing near each bit's centre.
    always_comb begin
        rx_state_n   = rx_state;
        rx_tcnt_n    = rx_tcnt;
        rx_idx_n     = rx_idx;
        rx_shift_n   = rx_shift;
        rx_stop_ok_n = rx_stop_ok;
        rx_done_n    = 1'b0;
        rx_data_n    = o_rx_data;
        stop_ok_now  = rx_stop_ok & rx_sync;
        case (rx_state)
            IDLE: begin
                if (!rx_sync) begin
                    rx_tcnt_n  = '0;
                    rx_state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_tcnt == MID_TICK) begin
                        rx_tcnt_n  = '0;
                        rx_idx_n   = '0;
                        rx_state_n = rx_sync ? IDLE : DATA;
                    end else begin
                        rx_tcnt_n = rx_tcnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (rx_tcnt == BIT_TICK) begin
                        rx_tcnt_n  = '0;
                        rx_shift_n = {rx_sync, rx_shift[DATA_WIDTH-1:1]};
                        if (rx_idx == DATA_LAST) begin
                            rx_idx_n     = '0;
                            rx_stop_ok_n = 1'b1;
                            rx_state_n   = STOP;
                        end else begin
                            rx_idx_n = rx_idx + 1'b1;
                        end
                    end else begin
                        rx_tcnt_n = rx_tcnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_tcnt == BIT_TICK) begin
                        rx_tcnt_n = '0;
                        if (rx_idx == STOP_LAST) begin
                            rx_idx_n   = '0;
                            rx_state_n = IDLE;
                            // Framing or parity failure drops the byte silently.
                            if (stop_ok_now && ((^rx_shift) == i_parity[0])) begin
                                rx_data_n = rx_shift;
                                rx_done_n = 1'b1;
                            end
                        end else begin
                            rx_idx_n     = rx_idx + 1'b1;
                            rx_stop_ok_n = stop_ok_now;
                        end
                    end else begin
                        rx_tcnt_n = rx_tcnt + 1'b1;
                    end
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_serial_link.sv
// Bench for uart_serial_link: a frame-level model of the transmitter and a
// scoreboard of expected received bytes are compared with the DUT on every
// falling clock edge; directed vectors add hand-computed literal checks.
module tb_uart_serial_link;

    localparam int BIT    = 256;
    localparam int NBITS  = 10;
    localparam int RX_MIN = 2400;   // stop mid-sample ~9.5 bits after the start edge
    localparam int RX_MAX = 2464;

    logic       clk = 1'b0, rst_n = 1'b1, sig = 1'b0;
    logic       line_drv = 1'b1, loop_sel = 1'b0, par_sel = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic [0:0] par_drv = 1'b0;
    logic       rx_line, rx_done, tx_line, tx_done, tx_avail;
    logic [0:0] par_in, par_out;
    logic [7:0] rx_data;

    int checks = 0, errors = 0, cyc = 0;

    // transmitter model
    logic       m_busy = 1'b0, m_done = 1'b0, m_prev = 1'b0;
    logic [0:0] m_par = 1'b0;
    logic [7:0] m_byte = 8'h00;
    int         m_el = 0;
    // receiver scoreboard
    logic [7:0] exp_q[$];
    int         t_q[$];
    logic [7:0] m_rx = 8'h00, sb_b;
    int         sb_t;
    logic       prev_rd = 1'b0;

    assign rx_line = loop_sel ? tx_line : line_drv;
    assign par_in  = par_sel ? par_drv : par_out;

    uart_serial_link dut (
        .i_clock(clk), .i_reset(rst_n), .i_rx_data(rx_line),
        .i_tx_signal(sig), .i_tx_result(tx_byte), .i_parity(par_in),
        .o_rx_done(rx_done), .o_rx_data(rx_data), .o_parity(par_out),
        .o_tx_data(tx_line), .o_tx_done(tx_done), .o_tx_available(tx_avail)
    );

    always #25 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Serial level of a frame at elapsed clock el: start, LSB-first data, stop.
    function automatic logic exp_line(input logic busy, input int el, input logic [7:0] b);
        int i;
        if (!busy) return 1'b1;
        i = el / BIT;
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_el <= 0; m_prev <= 1'b0; m_par <= 1'b0; m_done <= 1'b0;
        end else begin
            m_prev <= sig;
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_el == NBITS*BIT - 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_el <= 0;
                end else begin
                    m_el <= m_el + 1;
                end
            end else if (sig && !m_prev) begin
                m_busy <= 1'b1; m_el <= 0; m_byte <= tx_byte; m_par <= ^tx_byte;
            end
        end
    end

    always @(negedge clk) begin
        chk("tx_line", 32'(tx_line), 32'(exp_line(m_busy, m_el, m_byte)));
        chk("tx_available", 32'(tx_avail), 32'(!m_busy));
        chk("tx_done", 32'(tx_done), 32'(m_done));
        chk("tx_parity", 32'(par_out), 32'(m_par));
        if (!rst_n) begin
            exp_q.delete(); t_q.delete(); m_rx = 8'h00;
        end else if (rx_done) begin
            if (exp_q.size() == 0) begin
                chk("rx_done_spurious", 32'(rx_done), 32'(0));
            end else begin
                sb_b = exp_q.pop_front();
                sb_t = t_q.pop_front();
                chk("rx_byte", 32'(rx_data), 32'(sb_b));
                chk("rx_done_timing", 32'((cyc - sb_t) >= RX_MIN && (cyc - sb_t) <= RX_MAX), 32'(1));
                m_rx = sb_b;
            end
        end
        chk("rx_done_width", 32'(rx_done & prev_rd), 32'(0));
        chk("rx_data", 32'(rx_data), 32'(m_rx));
        prev_rd = rx_done;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Request pulse of 4 clocks; the line falls after the accepting edge.
    task automatic send_tx(input logic [7:0] b, input logic expect_rx);
        tx_byte = b;
        sig = 1'b1;
        if (expect_rx) begin
            exp_q.push_back(b); t_q.push_back(cyc + 2);
        end
        tick(4);
        sig = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic bad_stop, input logic expect_rx);
        par_drv  = ^b;
        line_drv = 1'b0;
        if (expect_rx) begin
            exp_q.push_back(b); t_q.push_back(cyc + 1);
        end
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            line_drv = b[i];
            tick(BIT);
        end
        if (bad_stop) begin
            line_drv = 1'b0; tick(160); line_drv = 1'b1; tick(BIT - 160);
        end else begin
            line_drv = 1'b1; tick(BIT);
        end
    endtask

    logic [9:0] a5_pat = 10'b1101001010;   // stop,d7..d0,start for 0xA5
    logic [7:0] lb[4] = '{8'h21, 8'h08, 8'h22, 8'h00};
    int done_at, dn;

    initial begin
        // 1. reset
        #2 rst_n = 1'b0;
        tick(8);
        chk("rst_tx_line", 32'(tx_line), 32'(1));
        chk("rst_tx_avail", 32'(tx_avail), 32'(1));
        chk("rst_tx_done", 32'(tx_done), 32'(0));
        chk("rst_rx_done", 32'(rx_done), 32'(0));
        chk("rst_rx_data", 32'(rx_data), 32'(0));
        chk("rst_parity", 32'(par_out), 32'(0));
        rst_n = 1'b1;
        tick(5);

        // 2. transmit 0xA5, bit-by-bit literal check at bit centres
        tx_byte = 8'hA5; sig = 1'b1;
        tick(1);
        done_at = -1;
        for (int j = 0; j < 3000 && done_at < 0; j++) begin
            if (j < NBITS*BIT && (j % BIT) == 128) chk("a5_bit", 32'(tx_line), 32'(a5_pat[j/BIT]));
            if (j == 1000) chk("a5_busy", 32'(tx_avail), 32'(0));
            if (tx_done) done_at = j;
            if (j == 3) sig = 1'b0;
            tick(1);
        end
        chk("a5_parity", 32'(par_out), 32'(0));
        chk("a5_done_clock", 32'(done_at >= 2559 && done_at <= 2561), 32'(1));
        chk("a5_avail_after", 32'(tx_avail), 32'(1));
        tick(20);

        // 3. loopback at 3072-clock spacing
        loop_sel = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_tx(lb[k], 1'b1);
            tick(3072 - 4);
            chk("loop_rx_data", 32'(rx_data), 32'(lb[k]));
        end
        chk("loop_pending", 32'(exp_q.size()), 32'(0));

        // back-to-back frames with no idle gap
        loop_sel = 1'b0; par_sel = 1'b1;
        tick(10);
        drive_frame(8'h3C, 1'b0, 1'b1);
        drive_frame(8'hC7, 1'b0, 1'b1);
        tick(300);
        chk("b2b_rx_data", 32'(rx_data), 32'(8'hC7));
        chk("b2b_pending", 32'(exp_q.size()), 32'(0));

        // 4. parity mismatch: 0xFF with partner parity forced to 1
        loop_sel = 1'b1; par_drv = 1'b1;
        send_tx(8'hFF, 1'b0);
        tick(3068);
        chk("pm_rx_data_kept", 32'(rx_data), 32'(8'hC7));
        chk("pm_tx_parity", 32'(par_out), 32'(0));
        loop_sel = 1'b0;
        tick(10);

        // 5. glitch, framing error, then a good frame
        line_drv = 1'b0; tick(3); line_drv = 1'b1;
        tick(400);
        chk("glitch_rx_data", 32'(rx_data), 32'(8'hC7));
        drive_frame(8'h5A, 1'b1, 1'b0);
        tick(600);
        chk("framing_rx_data", 32'(rx_data), 32'(8'hC7));
        drive_frame(8'hAA, 1'b0, 1'b1);
        tick(300);
        chk("aa_rx_data", 32'(rx_data), 32'(8'hAA));
        chk("aa_pending", 32'(exp_q.size()), 32'(0));

        // 6. request edge while busy is ignored
        par_sel = 1'b0;
        tx_byte = 8'h96; sig = 1'b1;
        tick(1);
        dn = 0;
        for (int j = 0; j < 2700; j++) begin
            if (j == 3) sig = 1'b0;
            if (j == 1000) begin sig = 1'b1; tx_byte = 8'h07; end
            if (j == 1004) sig = 1'b0;
            if (tx_done) dn++;
            tick(1);
        end
        chk("busy_done_count", 32'(dn), 32'(1));
        chk("busy_parity", 32'(par_out), 32'(0));

        // reset mid-frame aborts at once
        send_tx(8'h5A, 1'b0);
        tick(700);
        chk("abort_busy", 32'(tx_avail), 32'(0));
        #10 rst_n = 1'b0;
        #1;
        chk("abort_tx_line", 32'(tx_line), 32'(1));
        chk("abort_tx_avail", 32'(tx_avail), 32'(1));
        chk("abort_parity", 32'(par_out), 32'(0));
        tick(8);
        rst_n = 1'b1;
        tick(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
